// File: rtl/nibble_logic_unit.sv
// Digit-serial logic engine: computes a bitwise logic op on two WIDTH-bit operands DIGIT_W bits per cycle, LSB first.
// Optional parity output enabled by defining LOGIC_PARITY_EN.
module nibble_logic_unit #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef LOGIC_PARITY_EN
  output logic             parity,
`endif
  output logic             zero
);

  localparam int unsigned NDIG  = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;

  logic [1:0]         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_d;
  logic [2:0]         op_q, op_d;
  logic               in_ready_d, out_valid_d, zero_d;
  logic [DIGIT_W-1:0] a_dig, b_dig, r_dig;
`ifdef LOGIC_PARITY_EN
  logic               parity_d;
`endif

  // One digit of the selected bitwise operation; 111 (PASS a) is the default.
  function automatic logic [DIGIT_W-1:0] digit_op(input logic [2:0] code,
                                                  input logic [DIGIT_W-1:0] x,
                                                  input logic [DIGIT_W-1:0] y);
    case (code)
      OP_AND:  return x & y;
      OP_NAND: return ~(x & y);
      OP_OR:   return x | y;
      OP_NOR:  return ~(x | y);
      OP_XOR:  return x ^ y;
      OP_XNOR: return ~(x ^ y);
      OP_NOT:  return ~x;
      default: return x;
    endcase
  endfunction

  // Select the operand digits addressed by the counter.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (cnt == CNT_W'(k)) begin
        a_dig = a_q[k*DIGIT_W +: DIGIT_W];
        b_dig = b_q[k*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign r_dig = digit_op(op_q, a_dig, b_dig);

  // Next-state and registered-output values.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result;
    zero_d      = zero;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
`ifdef LOGIC_PARITY_EN
    parity_d    = parity;
`endif
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d    = S_BUSY;
          a_d        = a;
          b_d        = b;
          op_d       = op;
          result_d   = '0;
          cnt_d      = '0;
          zero_d     = 1'b0;
          in_ready_d = 1'b0;
`ifdef LOGIC_PARITY_EN
          parity_d   = 1'b0;
`endif
        end
      end
      S_BUSY: begin
        for (int unsigned k = 0; k < NDIG; k++) begin
          if (cnt == CNT_W'(k)) result_d[k*DIGIT_W +: DIGIT_W] = r_dig;
        end
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(NDIG - 1)) begin
          // Flags are taken from the completed result as DONE is entered.
          state_d     = S_DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          zero_d      = (result_d == '0);
`ifdef LOGIC_PARITY_EN
          parity_d    = ^result_d;
`endif
        end
      end
      S_DONE: begin
        if (out_valid && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          zero_d      = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        zero_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result    <= '0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef LOGIC_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result    <= result_d;
      zero      <= zero_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
`ifdef LOGIC_PARITY_EN
      parity    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_logic_unit.sv
// Self-checking bench for nibble_logic_unit: vector table plus scoreboard queue, with hand sequences for corner cases.
module tb_nibble_logic_unit;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        zero;
    logic        par;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        zero;
    logic        par;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
`ifdef LOGIC_PARITY_EN
  logic        parity;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[12];

  nibble_logic_unit #(.WIDTH(16), .DIGIT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef LOGIC_PARITY_EN
    .parity    (parity),
`endif
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operation, and records its expected outcome.
  task automatic send(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    tick();
    in_valid = 1'b0;
    sb.push_back(e);
    check("in_ready_low_busy", 32'(in_ready), 32'(0));
    check("out_valid_low_busy", 32'(out_valid), 32'(0));
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  // Compares the presented result with the scoreboard head, then completes the handshake.
  task automatic retire(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard actual=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_out_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_zero"}, 32'(zero), 32'(e.zero));
`ifdef LOGIC_PARITY_EN
    check({tag, "_parity"}, 32'(parity), 32'(e.par));
`endif
    out_ready = 1'b1;
    tick();
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'(0));
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'(1));
    check({tag, "_zero_after"}, 32'(zero), 32'(0));
  endtask

  initial begin
    int lat;
    exp_t e;

    vecs[0]  = '{3'b000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0};
    vecs[2]  = '{3'b100, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{3'b010, 16'h00FF, 16'h0F00, 16'h0FFF, 1'b0, 1'b0};
    vecs[4]  = '{3'b011, 16'hA5A5, 16'h0F0F, 16'h5050, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 16'h1234, 16'h00FF, 16'hED34, 1'b0, 1'b1};
    vecs[6]  = '{3'b110, 16'h0001, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1};
    vecs[7]  = '{3'b111, 16'hABCD, 16'h5555, 16'hABCD, 1'b0, 1'b0};
    vecs[8]  = '{3'b000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{3'b100, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1};
    vecs[10] = '{3'b110, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{3'b011, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'(1));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_result", 32'(result), 32'(0));
    check("reset_zero", 32'(zero), 32'(0));
`ifdef LOGIC_PARITY_EN
    check("reset_parity", 32'(parity), 32'(0));
`endif

    foreach (vecs[i]) begin
      e = '{vecs[i].res, vecs[i].zero, vecs[i].par};
      send(vecs[i].op, vecs[i].a, vecs[i].b, e);
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(4));
      retire($sformatf("vec%0d", i));
    end

    // Backpressure: result held while out_ready is low, stray in_valid ignored.
    out_ready = 1'b0;
    send(3'b010, 16'h00FF, 16'h0F00, '{16'h0FFF, 1'b0, 1'b0});
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'(4));
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_result", 32'(result), 32'(16'h0FFF));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      in_valid = (i % 2 == 0);
      a = 16'($urandom);
      op = 3'b000;
      tick();
    end
    in_valid = 1'b0;
    retire("bp");
    tick();
    check("bp_idle_in_ready", 32'(in_ready), 32'(1));
    check("bp_idle_out_valid", 32'(out_valid), 32'(0));

    // Reset during BUSY discards the pending operation.
    send(3'b011, 16'h0000, 16'h0000, '{16'hFFFF, 1'b0, 1'b0});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_result", 32'(result), 32'(0));
    check("midrst_zero", 32'(zero), 32'(0));
    tick();
    check("midrst_stays_idle", 32'(out_valid), 32'(0));
    send(3'b000, 16'hFFFF, 16'h8001, '{16'h8001, 1'b0, 1'b0});
    wait_out(lat);
    check("midrst_and_latency", 32'(lat), 32'(4));
    retire("midrst_and");

    // Digit order LSB first, and operand changes during BUSY have no effect.
    send(3'b111, 16'hABCD, 16'h0000, '{16'hABCD, 1'b0, 1'b0});
    a = 16'h0000;
    b = 16'hFFFF;
    op = 3'b000;
    check("digit_cleared", 32'(result), 32'(16'h0000));
    tick();
    check("digit0", 32'(result), 32'(16'h000D));
    tick();
    check("digit1", 32'(result), 32'(16'h00CD));
    tick();
    check("digit2", 32'(result), 32'(16'h0BCD));
    check("digit2_out_valid", 32'(out_valid), 32'(0));
    tick();
    retire("digit_pass");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
